// File: rtl/amem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : amem_pkg
// Description : Shared types for the CADR A-memory bank.
// Revision    : 1.0
// ============================================================================
package amem_pkg;

    typedef enum logic [0:0] {
        AMEM_IDLE  = 1'b0,
        AMEM_CLEAR = 1'b1
    } amem_state_e;

endpackage
`default_nettype wire

// File: rtl/amem_bank_if.sv
`default_nettype none
// ============================================================================
// Module      : amem_bank_if
// Description : Read/write/clear bus between microcode decode and A-memory.
// Revision    : 1.0
// ============================================================================
interface amem_bank_if #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 10
);
    logic [DEPTH_LOG2-1:0] raddr;
    logic                  arp;
    logic [WIDTH-1:0]      amem;
    logic [DEPTH_LOG2-1:0] waddr;
    logic [WIDTH-1:0]      l;
    logic                  awp;
    logic                  clr;
    logic                  busy;

    modport master (
        output raddr, arp, waddr, l, awp, clr,
        input  amem, busy
    );

    modport slave (
        input  raddr, arp, waddr, l, awp, clr,
        output amem, busy
    );
endinterface
`default_nettype wire

// File: rtl/part_dpram_param.sv
`default_nettype none
// ============================================================================
// Module      : part_dpram_param
// Description : WIDTH x 2**DEPTH_LOG2 RAM, one sync read and one sync write port.
// Revision    : 1.0
// ============================================================================
module part_dpram_param #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 10
) (
    input  wire logic                  clk,
    input  wire logic                  i_we,
    input  wire logic [DEPTH_LOG2-1:0] i_waddr,
    input  wire logic [WIDTH-1:0]      i_wdata,
    input  wire logic                  i_re,
    input  wire logic [DEPTH_LOG2-1:0] i_raddr,
    output logic      [WIDTH-1:0]      o_rdata
);
    localparam int c_DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0] r_mem [0:c_DEPTH-1];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;
endmodule
`default_nettype wire

// File: rtl/amem_bank.sv
`default_nettype none
// ============================================================================
// Module      : amem_bank
// Description : Parametrised A-memory with write-first forwarding and clear sweep.
// Revision    : 1.0
// ============================================================================
module amem_bank
    import amem_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter int DEPTH_LOG2    = 10,
    parameter int INIT_ON_RESET = 1
) (
    input  wire logic  clk,
    input  wire logic  reset,
    amem_bank_if.slave bus
);
    localparam int               c_AW       = DEPTH_LOG2;
    localparam logic [c_AW-1:0]  c_LAST     = {c_AW{1'b1}};
    localparam logic [0:0]       c_ST_IDLE  = AMEM_IDLE;
    localparam logic [0:0]       c_ST_CLEAR = AMEM_CLEAR;

    logic [0:0]       r_state;
    logic [c_AW-1:0]  r_clr_addr;
    logic             r_src_ram;
    logic [WIDTH-1:0] r_hold;

    logic             w_clear;
    logic             w_fwd;
    logic             w_we;
    logic [c_AW-1:0]  w_waddr;
    logic [WIDTH-1:0] w_wdata;
    logic             w_re;
    logic [WIDTH-1:0] w_rdata;

    assign w_clear = (r_state == c_ST_CLEAR);
    assign w_fwd   = bus.awp && bus.arp && (bus.raddr == bus.waddr);

    // Single write port: the sweep owns it while clearing, awp is simply dropped.
    assign w_we    = w_clear || bus.awp;
    assign w_waddr = w_clear ? r_clr_addr : bus.waddr;
    assign w_wdata = w_clear ? '0 : bus.l;
    assign w_re    = bus.arp && !reset && !w_clear && !w_fwd;

    part_dpram_param #(
        .WIDTH      (WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_re    (w_re),
        .i_raddr (bus.raddr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= (INIT_ON_RESET != 0) ? c_ST_CLEAR : c_ST_IDLE;
            r_clr_addr <= '0;
            r_src_ram  <= 1'b0;
            r_hold     <= '0;
        end else begin
            // amem is either the RAM's read register or r_hold (zero / forwarded).
            if (bus.arp) begin
                if (w_clear) begin
                    r_src_ram <= 1'b0;
                    r_hold    <= '0;
                end else if (w_fwd) begin
                    r_src_ram <= 1'b0;
                    r_hold    <= bus.l;
                end else begin
                    r_src_ram <= 1'b1;
                end
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (bus.clr) begin
                        r_state <= c_ST_CLEAR;
                    end
                end
                c_ST_CLEAR: begin
                    if (r_clr_addr == c_LAST) begin
                        r_state    <= c_ST_IDLE;
                        r_clr_addr <= '0;
                    end else begin
                        r_clr_addr <= r_clr_addr + 1'b1;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign bus.amem = r_src_ram ? w_rdata : r_hold;
    assign bus.busy = w_clear;
endmodule
`default_nettype wire

// File: tb/tb_amem_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_amem_bank
// Description : Randomised + directed bench for amem_bank (INIT_ON_RESET=1 and 0).
// Revision    : 1.0
// ============================================================================
module tb_amem_bank;
    localparam int c_DL = 4;
    localparam int c_D  = 16;
    localparam int c_W  = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             s_reset;
    logic [c_DL-1:0]  s_raddr, s_waddr;
    logic             s_arp, s_awp, s_clr;
    logic [c_W-1:0]   s_l;

    amem_bank_if #(.WIDTH(c_W), .DEPTH_LOG2(c_DL)) if1 ();
    amem_bank_if #(.WIDTH(c_W), .DEPTH_LOG2(c_DL)) if0 ();

    assign if1.raddr = s_raddr; assign if0.raddr = s_raddr;
    assign if1.waddr = s_waddr; assign if0.waddr = s_waddr;
    assign if1.arp   = s_arp;   assign if0.arp   = s_arp;
    assign if1.awp   = s_awp;   assign if0.awp   = s_awp;
    assign if1.clr   = s_clr;   assign if0.clr   = s_clr;
    assign if1.l     = s_l;     assign if0.l     = s_l;

    amem_bank #(.WIDTH(c_W), .DEPTH_LOG2(c_DL), .INIT_ON_RESET(1)) u_dut1 (
        .clk (clk), .reset (s_reset), .bus (if1.slave)
    );
    amem_bank #(.WIDTH(c_W), .DEPTH_LOG2(c_DL), .INIT_ON_RESET(0)) u_dut0 (
        .clk (clk), .reset (s_reset), .bus (if0.slave)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: a sweep is modelled as an instant wipe plus a busy window in
    // which reads return zero and writes vanish. Index 1 = INIT_ON_RESET=1.
    logic [c_W-1:0] m_mem   [2][c_D];
    bit             m_vld   [2][c_D];
    logic [c_W-1:0] m_amem  [2];
    bit             m_known [2];
    int             m_left  [2];

    task automatic wipe(int u);
        for (int a = 0; a < c_D; a++) begin
            m_mem[u][a] = '0;
            m_vld[u][a] = 1'b1;
        end
    endtask

    task automatic model_step(int u);
        if (s_reset) begin
            m_amem[u]  = '0;
            m_known[u] = 1'b1;
            m_left[u]  = (u == 1) ? c_D : 0;
            if (u == 1) wipe(u);
        end else if (m_left[u] > 0) begin
            if (s_arp) begin
                m_amem[u]  = '0;
                m_known[u] = 1'b1;
            end
            m_left[u]--;
        end else begin
            if (s_arp) begin
                if (s_awp && s_raddr == s_waddr) begin
                    m_amem[u]  = s_l;
                    m_known[u] = 1'b1;
                end else begin
                    m_amem[u]  = m_mem[u][s_raddr];
                    m_known[u] = m_vld[u][s_raddr];
                end
            end
            if (s_awp) begin
                m_mem[u][s_waddr] = s_l;
                m_vld[u][s_waddr] = 1'b1;
            end
            if (s_clr) begin
                m_left[u] = c_D;
                wipe(u);
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        check("busy1", {31'b0, if1.busy}, {31'b0, m_left[1] > 0});
        check("busy0", {31'b0, if0.busy}, {31'b0, m_left[0] > 0});
        check("amem1", if1.amem, m_amem[1]);
        if (m_known[0]) check("amem0", if0.amem, m_amem[0]);
    endtask

    task automatic quiet();
        s_reset = 1'b0; s_arp = 1'b0; s_awp = 1'b0; s_clr = 1'b0;
        s_raddr = '0;   s_waddr = '0; s_l = '0;
    endtask

    task automatic wr(int a, logic [31:0] d);
        quiet(); s_awp = 1'b1; s_waddr = c_DL'(a); s_l = d; cycle();
    endtask

    task automatic rd(int a);
        quiet(); s_arp = 1'b1; s_raddr = c_DL'(a); cycle();
    endtask

    task automatic wait_idle(string tag, int cnt_in, int exp_len);
        int cnt = cnt_in;
        int guard = 0;
        quiet();
        while (if1.busy && guard < 64) begin
            cycle();
            cnt += int'(if1.busy);
            guard++;
        end
        check(tag, cnt, exp_len);
    endtask

    initial begin
        int cnt;
        for (int u = 0; u < 2; u++) begin
            m_left[u] = 0; m_known[u] = 1'b0; m_amem[u] = '0;
            for (int a = 0; a < c_D; a++) m_vld[u][a] = 1'b0;
        end
        quiet();
        repeat (2) @(posedge clk);

        // Reset sweep, write during busy, first-cycle access on the INIT=0 bank
        s_reset = 1'b1; cycle();
        check("rst_amem1", if1.amem, 32'h0);
        check("rst_amem0", if0.amem, 32'h0);
        cnt = int'(if1.busy);
        wr(2, 32'hFFFF_FFFF); cnt += int'(if1.busy);
        rd(2);                cnt += int'(if1.busy);
        check("init0_rd", if0.amem, 32'hFFFF_FFFF);
        check("busy_rd",  if1.amem, 32'h0);
        wait_idle("sweep_len", cnt, c_D);
        for (int a = 0; a < c_D; a++) rd(a);
        rd(2);
        check("dropped_wr", if1.amem, 32'h0);

        // Write then readback, hold with arp low
        wr(3, 32'hDEAD_BEEF);
        rd(3);
        check("rd_deadbeef", if1.amem, 32'hDEAD_BEEF);
        quiet(); repeat (3) cycle();
        check("hold", if1.amem, 32'hDEAD_BEEF);

        // Forwarding, and a neighbouring address unaffected
        wr(5, 32'h1111_1111);
        wr(6, 32'h6666_6666);
        quiet(); s_awp = 1'b1; s_waddr = 5; s_l = 32'h2222_2222;
        s_arp = 1'b1; s_raddr = 5; cycle();
        check("fwd", if1.amem, 32'h2222_2222);
        quiet(); s_awp = 1'b1; s_waddr = 5; s_l = 32'h3333_3333;
        s_arp = 1'b1; s_raddr = 6; cycle();
        check("no_fwd", if1.amem, 32'h6666_6666);

        // clr sweep, reset at sweep cycle 7, clr during sweep ignored
        quiet(); s_clr = 1'b1; cycle();
        quiet(); repeat (6) cycle();
        s_reset = 1'b1; cycle();
        quiet();
        cnt = int'(if1.busy);
        for (int i = 0; i < 4; i++) begin
            s_clr = (i == 2);
            cycle();
            cnt += int'(if1.busy);
        end
        wait_idle("midreset_len", cnt, c_D);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            s_reset = ($urandom_range(0, 99) == 0);
            s_clr   = ($urandom_range(0, 39) == 0);
            s_arp   = $urandom_range(0, 1) == 1;
            s_awp   = $urandom_range(0, 1) == 1;
            s_raddr = c_DL'($urandom_range(0, c_D - 1));
            s_waddr = ($urandom_range(0, 3) == 0) ? s_raddr : c_DL'($urandom_range(0, c_D - 1));
            s_l     = $urandom;
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
